// File: rtl/mem_stage_seq.sv
// mem_stage_seq: multi-cycle memory stage between the EX/MEM and MEM/WB buffers.
// Owns the stack pointer, a word-addressed data memory and the sticky EPC.
// Each request is accepted only in IDLE. It walks through W0, then W1 for
// 32-bit accesses, then RESP. The o_valid strobe follows in the next cycle.
// A 32-bit value is stored big-word-first: A holds [31:16] and A+1 holds [15:0].
//
// Ports:
//   clk, i_reset          clock (rising edge), async active-high reset
//   i_valid / o_ready     request handshake (ready only in IDLE)
//   i_memRead/i_memWrite  load(pop) / store(push) select
//   i_en32, i_isStack     32-bit access, SP-relative access
//   i_isPushPc            push (pc+1)|flags as a 32-bit word
//   i_aluData             address for non-stack accesses, passed through
//   i_writeData           store data
//   i_pc, i_flags         instruction PC and CCR flags
//   i_clearEpc            clears EPC and its valid flag
//   o_valid               one-cycle response strobe
//   o_memData, o_aluData  registered load data / address pass-through
//   o_sp                  current stack pointer
//   o_exc                 00 none, 01 underflow, 10 overflow, 11 bad address
//   o_epc, o_epcValid     captured PC of the first uncleared exception
module mem_stage_seq #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int SP_INIT     = 2**ADDR_W - 1,
  parameter int STACK_LIMIT = 2**ADDR_W - 1024
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_memRead,
  input  logic                i_memWrite,
  input  logic                i_en32,
  input  logic                i_isStack,
  input  logic                i_isPushPc,
  input  logic [DATA_W-1:0]   i_aluData,
  input  logic [2*DATA_W-1:0] i_writeData,
  input  logic [31:0]         i_pc,
  input  logic [3:0]          i_flags,
  input  logic                i_clearEpc,
  output logic                o_valid,
  output logic [2*DATA_W-1:0] o_memData,
  output logic [DATA_W-1:0]   o_aluData,
  output logic [ADDR_W-1:0]   o_sp,
  output logic [1:0]          o_exc,
  output logic [31:0]         o_epc,
  output logic                o_epcValid
);
  localparam int AW2 = ADDR_W + 2;

  typedef enum logic [1:0] {IDLE, W0, W1, RESP} state_t;

  state_t                state;
  logic [ADDR_W-1:0]     sp;
  logic [DATA_W-1:0]     mem [2**ADDR_W];

  // Request latched at accept
  logic                  req_rd, req_wr, req_32, req_push, req_pop;
  logic [ADDR_W-1:0]     req_addr;
  logic [2*DATA_W-1:0]   req_wdata;
  logic [31:0]           req_pc;
  logic [1:0]            req_exc;
  logic [DATA_W-1:0]     req_alu;
  logic [DATA_W-1:0]     rd_hi;

  // Accept-time decode
  logic                  acc_wr, acc_32, acc_push, acc_pop;
  logic [AW2-1:0]        sp_x, n_x;
  logic [DATA_W:0]       alu_end;
  logic                  underflow, overflow, bad_addr;
  logic [1:0]            acc_exc;
  logic [ADDR_W-1:0]     acc_addr;
  logic [2*DATA_W-1:0]   acc_wdata;
  logic [31:0]           pc_word;

  // Memory port
  logic                  mem_we, resp_entry;
  logic [ADDR_W-1:0]     mem_a;
  logic [DATA_W-1:0]     mem_wd, mem_rd;

  assign o_ready = (state == IDLE);
  assign o_sp    = sp;

  assign acc_wr   = i_memWrite | i_isPushPc;
  assign acc_32   = i_en32 | i_isPushPc;
  assign acc_push = i_isStack & acc_wr;
  assign acc_pop  = i_isStack & ~acc_wr & i_memRead;

  assign sp_x    = AW2'(sp);
  assign n_x     = acc_32 ? AW2'(2) : AW2'(1);
  assign alu_end = (DATA_W+1)'(i_aluData) + (acc_32 ? (DATA_W+1)'(1) : (DATA_W+1)'(0));

  // Compared in ADDR_W+2 bits so SP +/- n can never wrap.
  assign underflow = acc_pop  && (sp_x + n_x > AW2'(SP_INIT));
  assign overflow  = acc_push && (sp_x + AW2'(1) < AW2'(STACK_LIMIT) + n_x);
  assign bad_addr  = !i_isStack && (i_memRead || acc_wr) && ((alu_end >> ADDR_W) != '0);

  always_comb begin
    acc_exc = 2'b00;
    if (underflow)     acc_exc = 2'b01;
    else if (overflow) acc_exc = 2'b10;
    else if (bad_addr) acc_exc = 2'b11;
  end

  always_comb begin
    acc_addr = ADDR_W'(i_aluData);
    if (acc_push)     acc_addr = acc_32 ? sp - ADDR_W'(1) : sp;
    else if (acc_pop) acc_addr = sp + ADDR_W'(1);
  end

  assign pc_word   = (i_pc + 32'd1) | {i_flags, 28'b0};
  assign acc_wdata = i_isPushPc ? (2*DATA_W)'(pc_word) : i_writeData;

  // W0 touches the base word, W1 the following one; faulted requests never write.
  assign mem_a  = (state == W1) ? req_addr + ADDR_W'(1) : req_addr;
  assign mem_we = !i_reset && (state == W0 || state == W1) && req_wr && (req_exc == 2'b00);
  assign mem_wd = (state == W0 && req_32) ? req_wdata[2*DATA_W-1:DATA_W]
                                          : req_wdata[DATA_W-1:0];
  assign mem_rd = mem[mem_a];
  assign resp_entry = (state == W0 && !req_32) || (state == W1);

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_wd;
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      sp         <= ADDR_W'(SP_INIT);
      o_epc      <= '0;
      o_epcValid <= 1'b0;
      o_valid    <= 1'b0;
      o_memData  <= '0;
      o_aluData  <= '0;
      o_exc      <= 2'b00;
      req_rd     <= 1'b0;
      req_wr     <= 1'b0;
      req_32     <= 1'b0;
      req_push   <= 1'b0;
      req_pop    <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_pc     <= '0;
      req_exc    <= 2'b00;
      req_alu    <= '0;
      rd_hi      <= '0;
    end else begin
      o_valid <= (state == RESP);
      o_exc   <= (state == RESP) ? req_exc : 2'b00;

      if (i_clearEpc) begin
        o_epc      <= '0;
        o_epcValid <= 1'b0;
      end

      case (state)
        IDLE: if (i_valid) begin
          req_rd    <= i_memRead;
          req_wr    <= acc_wr;
          req_32    <= acc_32;
          req_push  <= acc_push;
          req_pop   <= acc_pop;
          req_addr  <= acc_addr;
          req_wdata <= acc_wdata;
          req_pc    <= i_pc;
          req_exc   <= acc_exc;
          req_alu   <= i_aluData;
          state     <= W0;
        end
        W0: begin
          if (req_32) begin
            rd_hi <= mem_rd;
            state <= W1;
          end else begin
            state <= RESP;
          end
        end
        W1:      state <= RESP;
        default: state <= IDLE;
      endcase

      if (resp_entry) begin
        if (req_rd && req_exc == 2'b00)
          o_memData <= req_32 ? {rd_hi, mem_rd} : {{DATA_W{1'b0}}, mem_rd};
        else
          o_memData <= '0;
        o_aluData <= req_alu;
        if (req_exc == 2'b00) begin
          if (req_push)     sp <= sp - (req_32 ? ADDR_W'(2) : ADDR_W'(1));
          else if (req_pop) sp <= sp + (req_32 ? ADDR_W'(2) : ADDR_W'(1));
        end else if (!o_epcValid || i_clearEpc) begin
          // A capture in the same cycle as a clear takes precedence.
          o_epc      <= req_pc;
          o_epcValid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_seq.sv
module tb_mem_stage_seq;
  logic        clk = 1'b0;
  logic        i_reset, i_valid, i_memRead, i_memWrite, i_en32, i_isStack, i_isPushPc;
  logic [15:0] i_aluData;
  logic [31:0] i_writeData, i_pc;
  logic [3:0]  i_flags;
  logic        i_clearEpc;
  logic        o_ready, o_valid, o_epcValid;
  logic [31:0] o_memData, o_epc;
  logic [15:0] o_aluData;
  logic [11:0] o_sp;
  logic [1:0]  o_exc;

  mem_stage_seq dut (
    .clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_en32(i_en32),
    .i_isStack(i_isStack), .i_isPushPc(i_isPushPc), .i_aluData(i_aluData),
    .i_writeData(i_writeData), .i_pc(i_pc), .i_flags(i_flags),
    .i_clearEpc(i_clearEpc), .o_valid(o_valid), .o_memData(o_memData),
    .o_aluData(o_aluData), .o_sp(o_sp), .o_exc(o_exc), .o_epc(o_epc),
    .o_epcValid(o_epcValid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        rd, wr, e32, stk, ppc;
    logic [15:0] alu;
    logic [31:0] wdata, pc;
    logic [3:0]  flags;
    logic        chk_data;
    logic [31:0] exp_data;
    logic [1:0]  exp_exc;
    logic [11:0] exp_sp;
  } vec_t;

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
    logic [15:0] alu;
    logic [1:0]  exc;
    logic [11:0] sp;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, wr, e32, stk, ppc, input logic [15:0] alu,
                              input logic [31:0] wdata, pc, input logic [3:0] flags,
                              input logic chk_data, input logic [31:0] exp_data,
                              input logic [1:0] exp_exc, input logic [11:0] exp_sp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.e32 = e32; v.stk = stk; v.ppc = ppc;
    v.alu = alu; v.wdata = wdata; v.pc = pc; v.flags = flags;
    v.chk_data = chk_data; v.exp_data = exp_data; v.exp_exc = exp_exc; v.exp_sp = exp_sp;
    return v;
  endfunction

  task automatic drive_idle();
    i_valid = 0; i_memRead = 0; i_memWrite = 0; i_en32 = 0; i_isStack = 0;
    i_isPushPc = 0; i_aluData = '0; i_writeData = '0; i_pc = '0; i_flags = '0;
  endtask

  // Drive one request, push its expectation at accept, pop and compare at o_valid.
  task automatic do_req(input string nm, input vec_t v);
    exp_t e, got;
    int   acc, waited;
    @(negedge clk);
    waited = 0;
    while (!o_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!o_ready) begin
      chk({nm, "_ready_timeout"}, 32'(o_ready), 32'd1);
      return;
    end
    i_valid = 1; i_memRead = v.rd; i_memWrite = v.wr; i_en32 = v.e32;
    i_isStack = v.stk; i_isPushPc = v.ppc; i_aluData = v.alu;
    i_writeData = v.wdata; i_pc = v.pc; i_flags = v.flags;
    @(posedge clk);
    #1;
    acc = cyc;
    e.chk_data = v.chk_data; e.data = v.exp_data; e.alu = v.alu;
    e.exc = v.exp_exc; e.sp = v.exp_sp; e.lat = (v.e32 || v.ppc) ? 3 : 2;
    sb.push_back(e);
    drive_idle();
    waited = 0;
    while (!o_valid && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!o_valid) begin
      chk({nm, "_valid_timeout"}, 32'(o_valid), 32'd1);
      void'(sb.pop_front());
      return;
    end
    got = sb.pop_front();
    chk({nm, "_latency"}, 32'(cyc - acc), 32'(got.lat));
    if (got.chk_data) chk({nm, "_data"}, o_memData, got.data);
    chk({nm, "_alu"}, 32'(o_aluData), 32'(got.alu));
    chk({nm, "_exc"}, 32'(o_exc), 32'(got.exc));
    chk({nm, "_sp"}, 32'(o_sp), 32'(got.sp));
    @(posedge clk);
    #1;
    chk({nm, "_valid_drop"}, {30'd0, o_valid, |o_exc}, 32'd0);
  endtask

  vec_t vecs[17];

  initial begin
    i_reset = 1; i_clearEpc = 0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_sp", 32'(o_sp), 32'h0FFF);
    chk("rst_epc", o_epc, 32'd0);
    chk("rst_epcvalid", 32'(o_epcValid), 32'd0);
    chk("rst_memdata", o_memData, 32'd0);
    chk("rst_exc", 32'(o_exc), 32'd0);
    chk("rst_alu", 32'(o_aluData), 32'd0);
    @(negedge clk);
    i_reset = 0;

    //              rd wr 32 st pp  alu       wdata          pc            fl    cd exp_data      exc    sp
    vecs[0]  = mk(0, 1, 0, 0, 0, 16'h0000, 32'h0000_1111, 32'h0, 4'h0, 0, 32'h0,         2'b00, 12'hFFF);
    vecs[1]  = mk(0, 1, 0, 0, 0, 16'h0010, 32'h0000_BEEF, 32'h0, 4'h0, 0, 32'h0,         2'b00, 12'hFFF);
    vecs[2]  = mk(1, 0, 0, 0, 0, 16'h0010, 32'h0,         32'h0, 4'h0, 1, 32'h0000_BEEF, 2'b00, 12'hFFF);
    vecs[3]  = mk(0, 1, 1, 0, 0, 16'h0020, 32'h1234_5678, 32'h0, 4'h0, 0, 32'h0,         2'b00, 12'hFFF);
    vecs[4]  = mk(1, 0, 0, 0, 0, 16'h0020, 32'h0,         32'h0, 4'h0, 1, 32'h0000_1234, 2'b00, 12'hFFF);
    vecs[5]  = mk(1, 0, 0, 0, 0, 16'h0021, 32'h0,         32'h0, 4'h0, 1, 32'h0000_5678, 2'b00, 12'hFFF);
    vecs[6]  = mk(1, 0, 1, 0, 0, 16'h0020, 32'h0,         32'h0, 4'h0, 1, 32'h1234_5678, 2'b00, 12'hFFF);
    vecs[7]  = mk(0, 1, 1, 1, 1, 16'h0000, 32'h0,         32'h40, 4'hA, 0, 32'h0,        2'b00, 12'hFFD);
    vecs[8]  = mk(1, 0, 1, 1, 0, 16'h0000, 32'h0,         32'h0, 4'h0, 1, 32'hA000_0041, 2'b00, 12'hFFF);
    vecs[9]  = mk(0, 1, 0, 1, 0, 16'h0000, 32'h0000_7777, 32'h0, 4'h0, 0, 32'h0,         2'b00, 12'hFFE);
    vecs[10] = mk(1, 0, 0, 1, 0, 16'h0000, 32'h0,         32'h0, 4'h0, 1, 32'h0000_7777, 2'b00, 12'hFFF);
    vecs[11] = mk(1, 0, 0, 1, 0, 16'h0000, 32'h0,         32'h100, 4'h0, 1, 32'h0,       2'b01, 12'hFFF);
    vecs[12] = mk(1, 0, 1, 1, 0, 16'h0000, 32'h0,         32'h200, 4'h0, 1, 32'h0,       2'b01, 12'hFFF);
    vecs[13] = mk(1, 0, 1, 0, 0, 16'h0FFF, 32'h0,         32'h0, 4'h0, 1, 32'h0,         2'b11, 12'hFFF);
    vecs[14] = mk(0, 1, 0, 0, 0, 16'h1000, 32'h0000_5555, 32'h0, 4'h0, 0, 32'h0,         2'b11, 12'hFFF);
    vecs[15] = mk(1, 0, 0, 0, 0, 16'h0000, 32'h0,         32'h0, 4'h0, 1, 32'h0000_1111, 2'b00, 12'hFFF);
    vecs[16] = mk(0, 1, 0, 0, 0, 16'h0031, 32'h0000_CCCC, 32'h0, 4'h0, 0, 32'h0,         2'b00, 12'hFFF);

    for (int i = 0; i < 17; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i]);
      if (i == 11) begin
        chk("epc_first", o_epc, 32'h100);
        chk("epcvalid_first", 32'(o_epcValid), 32'd1);
      end
    end

    // Second fault (pc 0x200) and later ones must not overwrite the sticky EPC.
    chk("epc_sticky", o_epc, 32'h100);
    chk("epcvalid_sticky", 32'(o_epcValid), 32'd1);

    @(negedge clk);
    i_clearEpc = 1;
    @(negedge clk);
    i_clearEpc = 0;
    chk("epc_cleared", o_epc, 32'd0);
    chk("epcvalid_cleared", 32'(o_epcValid), 32'd0);

    // Fill the stack down to its limit, then one more push must overflow.
    for (int i = 0; i < 512; i++)
      do_req($sformatf("fill%0d", i),
             mk(0, 1, 1, 1, 0, 16'h0, 32'hC0DE_0000 | 32'(i), 32'h0, 4'h0,
                0, 32'h0, 2'b00, 12'(12'hFFF - 12'(2 * (i + 1)))));
    do_req("overflow", mk(0, 1, 0, 1, 0, 16'h0, 32'h0000_9999, 32'h300, 4'h0,
                          0, 32'h0, 2'b10, 12'hBFF));
    chk("epc_overflow", o_epc, 32'h300);
    chk("epcvalid_overflow", 32'(o_epcValid), 32'd1);

    // Reset during W1 of a 32-bit store: high word lands, low word does not.
    @(negedge clk);
    i_valid = 1; i_memWrite = 1; i_en32 = 1; i_aluData = 16'h0030;
    i_writeData = 32'hAAAA_BBBB;
    @(posedge clk);
    #1;
    drive_idle();
    @(posedge clk);
    #1;
    i_reset = 1;
    #1;
    chk("midrst_ready", 32'(o_ready), 32'd1);
    chk("midrst_sp", 32'(o_sp), 32'h0FFF);
    chk("midrst_epcvalid", 32'(o_epcValid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    i_reset = 0;
    do_req("midrst_hi", mk(1, 0, 0, 0, 0, 16'h0030, 32'h0, 32'h0, 4'h0,
                           1, 32'h0000_AAAA, 2'b00, 12'hFFF));
    do_req("midrst_lo", mk(1, 0, 0, 0, 0, 16'h0031, 32'h0, 32'h0, 4'h0,
                           1, 32'h0000_CCCC, 2'b00, 12'hFFF));

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
